gps_time_disp_ctrl: RTL and testbench



---
 rtl/gps_disp_pkg.sv | 9 +
 rtl/sec_tick_gen.sv | 30 +++
 rtl/gps_time_disp_ctrl.sv | 101 ++++++++++
 tb/tb_gps_time_disp_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/gps_disp_pkg.sv
// gps_disp_pkg: shared state encoding, field limits and display constants for gps_time_disp_ctrl
package gps_disp_pkg;
    typedef enum logic [1:0] {NOFIX = 2'd0, LOCKED = 2'd1, HOLDOVER = 2'd2} state_t;
    localparam logic [5:0] SEP_POINT = 6'b010100;
    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;
    localparam int DATA_W   = 20;
endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: 1 s tick generator counting 0..CLK_FREQ-1
// Ports: clk, rst_n (async active-low), en (count enable), clr (restart at 0),
//        tick (pulse at CLK_FREQ-1 while enabled), half (first half-second).
// Macro: HOLDOVER_BLINK_EN builds the half-second compare; otherwise half is tied high.
module sec_tick_gen #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic half
);
    localparam int W = CLK_FREQ > 1 ? $clog2(CLK_FREQ) : 1;
    logic [W-1:0] cnt;
    assign tick = en && cnt == W'(CLK_FREQ - 1);
`ifdef HOLDOVER_BLINK_EN
    assign half = cnt < W'(CLK_FREQ / 2);
`else
    assign half = 1'b1;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/gps_time_disp_ctrl.sv
// gps_time_disp_ctrl: GPS UTC to local-time display controller with holdover clock
// Ports: sys_clk, sys_rst_n (async active-low); gps_hour/min/sec, gps_vld, gps_fix from
//        the RMC decoder; data/point/seg_en/sign to seg_595_dynamic; sync_ok while LOCKED.
// Macro: HOLDOVER_BLINK_EN blinks the separators at 1 Hz in HOLDOVER (see sec_tick_gen).
module gps_time_disp_ctrl
    import gps_disp_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TZ_HOUR  = 8,
    parameter int HOLD_SEC = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [4:0]        gps_hour,
    input  logic [5:0]        gps_min,
    input  logic [5:0]        gps_sec,
    input  logic              gps_vld,
    input  logic              gps_fix,
    output logic [DATA_W-1:0] data,
    output logic [5:0]        point,
    output logic              seg_en,
    output logic              sign,
    output logic              sync_ok
);
    state_t            state, state_nxt;
    logic [4:0]        hh;
    logic [5:0]        mm, ss;
    logic [3:0]        miss;
    logic              tick, half, accept;
    logic [5:0]        hsum;
    logic [4:0]        hh_load;
    logic [DATA_W-1:0] data_nxt;
    logic [5:0]        point_nxt;
    logic              seg_en_nxt, sync_ok_nxt;

    assign accept  = gps_vld && gps_fix && gps_hour <= 5'(HOUR_MAX) &&
                     gps_min <= 6'(MIN_MAX) && gps_sec <= 6'(SEC_MAX);
    assign hsum    = {1'b0, gps_hour} + 6'(TZ_HOUR);
    assign hh_load = hsum >= 6'd24 ? 5'(hsum - 6'd24) : hsum[4:0];
    assign sign    = 1'b0;

    sec_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .en    (state != NOFIX),
        .clr   (accept),
        .tick  (tick),
        .half  (half)
    );

    // A load always beats a coincident tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            hh   <= '0;
            mm   <= '0;
            ss   <= '0;
            miss <= '0;
        end else if (accept) begin
            hh   <= hh_load;
            mm   <= gps_min;
            ss   <= gps_sec;
            miss <= '0;
        end else if (tick) begin
            ss   <= ss == 6'(SEC_MAX) ? '0 : ss + 1'b1;
            mm   <= ss == 6'(SEC_MAX) ? (mm == 6'(MIN_MAX) ? '0 : mm + 1'b1) : mm;
            hh   <= (ss == 6'(SEC_MAX) && mm == 6'(MIN_MAX)) ?
                    (hh == 5'(HOUR_MAX) ? '0 : hh + 1'b1) : hh;
            miss <= miss == 4'(HOLD_SEC) ? miss : miss + 1'b1;
        end

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n)
            state <= NOFIX;
        else
            state <= state_nxt;

    // Leave LOCKED on the tick that brings the miss count to HOLD_SEC.
    always_comb
        state_nxt = accept ? LOCKED :
                    (state == LOCKED && tick && miss == 4'(HOLD_SEC - 1)) ? HOLDOVER : state;

    always_comb begin
        data_nxt    = DATA_W'(hh) * DATA_W'(10000) + DATA_W'(mm) * DATA_W'(100) + DATA_W'(ss);
        point_nxt   = (state == NOFIX || (state == HOLDOVER && !half)) ? 6'b0 : SEP_POINT;
        seg_en_nxt  = state != NOFIX;
        sync_ok_nxt = state == LOCKED;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            data    <= '0;
            point   <= '0;
            seg_en  <= 1'b0;
            sync_ok <= 1'b0;
        end else begin
            data    <= data_nxt;
            point   <= point_nxt;
            seg_en  <= seg_en_nxt;
            sync_ok <= sync_ok_nxt;
        end
endmodule

// File: tb/tb_gps_time_disp_ctrl.sv
// tb_gps_time_disp_ctrl: seconds-of-day reference model plus directed literal checks
module tb_gps_time_disp_ctrl;
    localparam int CF = 10;
`ifdef HOLDOVER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    logic        sys_clk = 1'b0, sys_rst_n = 1'b0;
    logic [4:0]  gps_hour = '0;
    logic [5:0]  gps_min = '0, gps_sec = '0;
    logic        gps_vld = 1'b0, gps_fix = 1'b0;
    logic [19:0] data;
    logic [5:0]  point;
    logic        seg_en, sign, sync_ok;
    int          n_chk = 0, n_fail = 0;
    bit          en_cmp = 1'b0;

    always #5 sys_clk = ~sys_clk;

    gps_time_disp_ctrl #(.CLK_FREQ(CF), .TZ_HOUR(8), .HOLD_SEC(3)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .gps_hour  (gps_hour),
        .gps_min   (gps_min),
        .gps_sec   (gps_sec),
        .gps_vld   (gps_vld),
        .gps_fix   (gps_fix),
        .data      (data),
        .point     (point),
        .seg_en    (seg_en),
        .sign      (sign),
        .sync_ok   (sync_ok)
    );

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time of day in seconds, phase within the current second, ticks since last load,
    // mode 0 = no fix, 1 = locked, 2 = holdover. Outputs lag the model by one clock.
    int   m_tod, m_phase, m_since, m_mode;
    int   exp_data, exp_point;
    bit   exp_seg, exp_sync;
    wire  m_acc = gps_vld && gps_fix && gps_hour < 24 && gps_min < 60 && gps_sec < 60;

    always @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            m_tod <= 0; m_phase <= 0; m_since <= 0; m_mode <= 0;
            exp_data <= 0; exp_point <= 0; exp_seg <= 0; exp_sync <= 0;
        end else begin
            exp_data  <= (m_tod / 3600) * 10000 + (m_tod / 60 % 60) * 100 + m_tod % 60;
            exp_seg   <= m_mode != 0;
            exp_sync  <= m_mode == 1;
            exp_point <= (m_mode == 0 || (BLINK && m_mode == 2 && m_phase >= CF / 2)) ? 0 : 20;
            if (m_acc) begin
                m_tod   <= ((int'(gps_hour) + 8) % 24) * 3600 + int'(gps_min) * 60 + int'(gps_sec);
                m_phase <= 0;
                m_since <= 0;
                m_mode  <= 1;
            end else if (m_mode != 0) begin
                m_phase <= (m_phase + 1) % CF;
                if (m_phase == CF - 1) begin
                    m_tod   <= (m_tod + 1) % 86400;
                    m_since <= m_since < 3 ? m_since + 1 : 3;
                    if (m_mode == 1 && m_since + 1 >= 3) m_mode <= 2;
                end
            end
        end

    always @(negedge sys_clk)
        if (en_cmp) begin
            chk("data", int'(data), exp_data);
            chk("point", int'(point), exp_point);
            chk("seg_en", int'(seg_en), int'(exp_seg));
            chk("sync_ok", int'(sync_ok), int'(exp_sync));
            chk("sign", int'(sign), 0);
        end

    task automatic load(int h, int m, int s, bit f);
        @(posedge sys_clk);
        #1 gps_hour = 5'(h); gps_min = 6'(m); gps_sec = 6'(s); gps_fix = f; gps_vld = 1'b1;
        @(posedge sys_clk);
        #1 gps_vld = 1'b0; gps_fix = 1'b0;
    endtask

    task automatic wait_out();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        en_cmp = 1'b1;
        repeat (50) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst data", int'(data), 0);
        chk("rst point", int'(point), 0);
        chk("rst seg_en", int'(seg_en), 0);
        chk("rst sync_ok", int'(sync_ok), 0);
        chk("rst sign", int'(sign), 0);
        load(0, 0, 60, 1'b1);
        load(4, 5, 6, 1'b0);
        load(24, 0, 0, 1'b1);
        wait_out();
        chk("nofix ignore seg_en", int'(seg_en), 0);
        chk("nofix ignore data", int'(data), 0);
        load(4, 5, 6, 1'b1);
        wait_out();
        chk("load data", int'(data), 120506);
        chk("load point", int'(point), 20);
        chk("load seg_en", int'(seg_en), 1);
        chk("load sync_ok", int'(sync_ok), 1);
        repeat (9) @(negedge sys_clk);
        chk("pre tick data", int'(data), 120506);
        @(negedge sys_clk);
        chk("tick data", int'(data), 120507);
        load(15, 59, 59, 1'b1);
        wait_out();
        chk("wrap load data", int'(data), 235959);
        repeat (10) @(negedge sys_clk);
        chk("midnight data", int'(data), 0);
        chk("midnight seg_en", int'(seg_en), 1);
        load(1, 2, 3, 1'b1);
        wait_out();
        chk("hold load data", int'(data), 90203);
        repeat (29) @(negedge sys_clk);
        chk("before holdover sync_ok", int'(sync_ok), 1);
        @(negedge sys_clk);
        chk("holdover sync_ok", int'(sync_ok), 0);
        chk("holdover data", int'(data), 90206);
        repeat (12) @(negedge sys_clk);
        load(5, 5, 5, 1'b0);
        wait_out();
        chk("holdover nofix strobe", int'(sync_ok), 0);
        load(1, 2, 3, 1'b1);
        wait_out();
        chk("relock sync_ok", int'(sync_ok), 1);
        chk("relock data", int'(data), 90203);
        repeat (7) @(posedge sys_clk);
        load(10, 20, 30, 1'b1);
        wait_out();
        chk("collide data", int'(data), 182030);
        repeat (9) @(negedge sys_clk);
        chk("collide hold data", int'(data), 182030);
        @(negedge sys_clk);
        chk("collide next tick", int'(data), 182031);
        repeat (3) @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async rst data", int'(data), 0);
        chk("async rst seg_en", int'(seg_en), 0);
        chk("async rst sync_ok", int'(sync_ok), 0);
        chk("async rst point", int'(point), 0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (30) @(negedge sys_clk);
        chk("post rst seg_en", int'(seg_en), 0);
        chk("post rst data", int'(data), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
